// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: duty-cycle ramp sequencer for the free-running PWM generator.
// Takes a target duty and step over valid/ready, then walks `value` toward the
// target one step every DWELL PWM periods. `value` only ever changes on the
// last clock of a period, so the generator never sees a glitched period.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | waiting for a command; cmd_ready high (outside reset)
// S_RAMP | stepping value toward tgt at period boundaries; busy high
module pwm_ramp_ctrl #(
  parameter int PERIOD_BITS = 3,
  parameter int DWELL       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [8:0] cmd_target,
  input  logic [3:0] cmd_step,
  input  logic       hold,
  output logic [8:0] value,
  output logic       sync,
  output logic       busy,
  output logic       done
);

  localparam logic [9:0] DMAX = 10'(1 << PERIOD_BITS);
  localparam int DW_BITS = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_BITS-1:0] DW_RELOAD = DW_BITS'(DWELL - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RAMP = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [PERIOD_BITS-1:0] cnt;
  logic [DW_BITS-1:0]   dwell;
  logic [8:0]           tgt;
  logic [3:0]           stp;
  logic                 done_q;

  logic       boundary;
  logic       accept;
  logic [9:0] cmd_tgt_c;
  logic [3:0] cmd_stp_c;
  logic [9:0] value10;
  logic [9:0] tgt10;
  logic [9:0] stp10;
  logic       up;
  logic [9:0] diff;
  logic [9:0] delta;
  logic [9:0] value_step;
  logic       step_now;
  logic       dwell_dec;
  logic       load_ramp;
  logic       done_set;

  // Command clamping and the step arithmetic, all done in 10 bits so the
  // distance to the target can never wrap.
  always_comb begin
    boundary   = (cnt == '1);
    accept     = cmd_valid & cmd_ready;
    cmd_tgt_c  = ({1'b0, cmd_target} > DMAX) ? DMAX : {1'b0, cmd_target};
    cmd_stp_c  = (cmd_step == 4'd0) ? 4'd1 : cmd_step;
    value10    = {1'b0, value};
    tgt10      = {1'b0, tgt};
    stp10      = {6'b0, stp};
    up         = (tgt10 > value10);
    diff       = up ? (tgt10 - value10) : (value10 - tgt10);
    delta      = (diff > stp10) ? stp10 : diff;
    value_step = up ? (value10 + delta) : (value10 - delta);
    step_now   = (state == S_RAMP) & boundary & ~hold & (dwell == '0);
    dwell_dec  = (state == S_RAMP) & boundary & ~hold & (dwell != '0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; an accept on a boundary is not counted because the
  // FSM is still in IDLE on that edge.
  always_comb begin
    state_nxt = state;
    load_ramp = 1'b0;
    done_set  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (cmd_tgt_c == value10) begin
            done_set = 1'b1;
          end else begin
            state_nxt = S_RAMP;
            load_ramp = 1'b1;
          end
        end
      end
      S_RAMP: begin
        if (step_now && (value_step == tgt10)) begin
          state_nxt = S_IDLE;
          done_set  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Phase counter, latched command, dwell timer and the duty register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      value  <= '0;
      tgt    <= '0;
      stp    <= 4'd1;
      dwell  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt    <= cnt + PERIOD_BITS'(1);
      done_q <= done_set;
      if (accept) begin
        tgt <= 9'(cmd_tgt_c);
        stp <= cmd_stp_c;
      end
      if (load_ramp) begin
        dwell <= DW_RELOAD;
      end else if (step_now) begin
        value <= 9'(value_step);
        dwell <= DW_RELOAD;
      end else if (dwell_dec) begin
        dwell <= dwell - DW_BITS'(1);
      end
    end
  end

  // Status outputs are forced low for as long as reset is held.
  always_comb begin
    cmd_ready = (state == S_IDLE) & ~rst;
    busy      = (state == S_RAMP) & ~rst;
    sync      = (cnt == '0) & ~rst;
    done      = done_q & ~rst;
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed scenarios followed by random traffic,
// every output compared each cycle against a value-schedule reference model.
module tb_pwm_ramp_ctrl;

  localparam int PB    = 3;
  localparam int DW    = 4;
  localparam int DMAX  = 1 << PB;
  localparam int PLEN  = 1 << PB;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [8:0] cmd_target;
  logic [3:0] cmd_step;
  logic       hold;
  logic [8:0] value;
  logic       sync;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_phase;
  int m_value;
  bit m_busy;
  bit m_done;
  int m_eff;
  int m_sched[$];

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(.PERIOD_BITS(PB), .DWELL(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_step   (cmd_step),
    .hold       (hold),
    .value      (value),
    .sync       (sync),
    .busy       (busy),
    .done       (done)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_phase = 0;
    m_value = 0;
    m_busy  = 0;
    m_done  = 0;
    m_eff   = 0;
    m_sched.delete();
  endfunction

  // Advance the model across one clock edge with the inputs held before it.
  // An accepted ramp is expanded up front into the list of duties it will
  // visit; one entry is consumed every DWELL un-held boundaries.
  function automatic void model_edge(input bit r, input bit v, input int tg, input int st, input bit h);
    bit boundary;
    int t, s, x, d, inc;
    if (r) begin
      model_reset();
      return;
    end
    boundary = (m_phase == PLEN - 1);
    m_phase  = (m_phase + 1) % PLEN;
    m_done   = 0;
    if (m_busy) begin
      if (boundary && !h) begin
        m_eff++;
        if (m_eff % DW == 0) begin
          m_value = m_sched.pop_front();
          if (m_sched.size() == 0) begin
            m_busy = 0;
            m_done = 1;
          end
        end
      end
    end else if (v) begin
      t = (tg > DMAX) ? DMAX : tg;
      s = (st == 0) ? 1 : st;
      if (t == m_value) begin
        m_done = 1;
      end else begin
        x = m_value;
        while (x != t) begin
          d   = (t > x) ? t - x : x - t;
          inc = (d < s) ? d : s;
          x   = (t > x) ? x + inc : x - inc;
          m_sched.push_back(x);
        end
        m_busy = 1;
        m_eff  = 0;
      end
    end
  endfunction

  // One clock: drive inputs, compare all outputs mid-cycle, step the model.
  task automatic drive_cycle(input bit r, input bit v, input int tg, input int st, input bit h);
    #1;
    rst        = r;
    cmd_valid  = v;
    cmd_target = 9'(tg);
    cmd_step   = 4'(st);
    hold       = h;
    #1;
    check_val("value",     value,     m_value);
    check_val("busy",      busy,      !r && m_busy);
    check_val("done",      done,      !r && m_done);
    check_val("sync",      sync,      !r && (m_phase == 0));
    check_val("cmd_ready", cmd_ready, !r && !m_busy);
    model_edge(r, v, tg, st, h);
    @(posedge clk);
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while (m_busy && n < budget) begin
      drive_cycle(0, 0, 0, 0, 0);
      n++;
    end
    if (m_busy) check_val("ramp_timeout", 1, 0);
    drive_cycle(0, 0, 0, 0, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_target = '0; cmd_step = '0; hold = 1'b0;
    repeat (3) @(posedge clk);
    model_reset();

    // target 8 step 2 from reset
    drive_cycle(0, 1, 8, 2, 0);
    run_idle(200);
    check_val("ramp_up_final", value, 8);

    // 8 -> 3 with step 2, last step clipped
    drive_cycle(0, 1, 3, 2, 0);
    run_idle(200);
    check_val("ramp_down_final", value, 3);

    // clamped target and zero step, from 0
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(0, 1, 20, 0, 0);
    run_idle(400);
    check_val("clamp_final", value, 8);

    // equal target: done without busy
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(0, 1, 0, 5, 0);
    drive_cycle(0, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 0);
    check_val("equal_value", value, 0);

    // hold across two boundaries, plus a command offered while busy
    drive_cycle(0, 1, 8, 1, 0);
    repeat (20) drive_cycle(0, 0, 0, 0, 0);
    repeat (16) drive_cycle(0, 0, 0, 0, 1);
    repeat (10) drive_cycle(0, 1, 0, 3, 0);
    run_idle(400);
    check_val("hold_final", value, 8);

    // reset mid-ramp at value 4, then a fresh ramp from 0
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(0, 1, 8, 2, 0);
    n = 0;
    while (m_value != 4 && n < 200) begin
      drive_cycle(0, 0, 0, 0, 0);
      n++;
    end
    if (m_value != 4) check_val("reach4_timeout", 1, 0);
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(0, 1, 5, 3, 0);
    run_idle(200);
    check_val("fresh_final", value, 5);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive_cycle($urandom_range(0, 299) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 12),
                  $urandom_range(0, 15),
                  $urandom_range(0, 6) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
